// File: rtl/pe_dot_sequencer_if.sv
// Bundle of command, operand-stream, PE-drive and result signals for one pe_dot_sequencer.
// The master modport is the sequencer's view; slave is the surrounding buffers/PE/consumer.
interface pe_dot_sequencer_if #(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_wgt;
    logic [DATA_W-1:0] in_ipt;

    logic [DATA_W-1:0] pe_wgt;
    logic [DATA_W-1:0] pe_ipt;
    logic              pe_accum;
    logic [DATA_W-1:0] pe_result;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (
        input  start, len, in_valid, in_wgt, in_ipt, pe_result, res_ready,
        output busy, in_ready, pe_wgt, pe_ipt, pe_accum, res_valid, res_data
    );

    modport slave (
        output start, len, in_valid, in_wgt, in_ipt, pe_result, res_ready,
        input  busy, in_ready, pe_wgt, pe_ipt, pe_accum, res_valid, res_data
    );
endinterface

// File: rtl/pe_dot_sequencer.sv
// Streams N FP16 operand pairs into one MAC PE (clear on first, accumulate after),
// waits for the PE pipeline to drain, then returns the captured sum on a valid/ready port.
module pe_dot_sequencer #(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned DATA_W = 16
) (
    input logic                clk,
    input logic                rst,
    pe_dot_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StOut
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   elem_cnt_q, elem_cnt_d;
    logic [1:0]         drain_cnt_q, drain_cnt_d;
    logic [DATA_W-1:0]  pe_wgt_q, pe_wgt_d;
    logic [DATA_W-1:0]  pe_ipt_q, pe_ipt_d;
    logic               pe_accum_q, pe_accum_d;
    logic               res_valid_q, res_valid_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        elem_cnt_d  = elem_cnt_q;
        drain_cnt_d = drain_cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        pe_wgt_d    = '0;
        pe_ipt_d    = '0;
        pe_accum_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && (bus.len != '0)) begin
                    len_d      = bus.len;
                    elem_cnt_d = '0;
                    state_d    = StFeed;
                end
            end
            StFeed: begin
                // Bubbles feed 0*0 with accumulate so the PE holds its running sum.
                pe_accum_d = 1'b1;
                if (bus.in_valid) begin
                    pe_wgt_d   = bus.in_wgt;
                    pe_ipt_d   = bus.in_ipt;
                    pe_accum_d = (elem_cnt_q != '0);
                    elem_cnt_d = elem_cnt_q + LEN_W'(1);
                    if (elem_cnt_q == (len_q - LEN_W'(1))) begin
                        drain_cnt_d = 2'd2;
                        state_d     = StDrain;
                    end
                end
            end
            StDrain: begin
                // Three cycles cover the PE's product and sum registers.
                pe_accum_d = 1'b1;
                if (drain_cnt_q == 2'd0) begin
                    res_data_d  = bus.pe_result;
                    res_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end
            end
            StOut: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            elem_cnt_q  <= '0;
            drain_cnt_q <= '0;
            pe_wgt_q    <= '0;
            pe_ipt_q    <= '0;
            pe_accum_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            elem_cnt_q  <= elem_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            pe_wgt_q    <= pe_wgt_d;
            pe_ipt_q    <= pe_ipt_d;
            pe_accum_q  <= pe_accum_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        bus.busy      = (state_q != StIdle);
        bus.in_ready  = (state_q == StFeed);
        bus.pe_wgt    = pe_wgt_q;
        bus.pe_ipt    = pe_ipt_q;
        bus.pe_accum  = pe_accum_q;
        bus.res_valid = res_valid_q;
        bus.res_data  = res_data_q;
    end

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Bench for pe_dot_sequencer: a two-stage FP16 MAC PE model, operand driver and a
// result scoreboard checking dot-product values and start-to-valid latency.
module tb_pe_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;

    pe_dot_sequencer_if #(.LEN_W(8), .DATA_W(16)) bus ();

    pe_dot_sequencer #(.LEN_W(8), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic real h2r(input logic [15:0] h);
        int  e;
        real v;
        e = int'(h[14:10]);
        v = real'(int'(h[9:0])) / 1024.0;
        if (e != 0) v = v + 1.0;
        else e = 1;
        if (e >= 15) repeat (e - 15) v = v * 2.0;
        else repeat (15 - e) v = v / 2.0;
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] h2h_from_real(input real r);
        int   e;
        int   m;
        real  a;
        logic s;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 15;
        while (a >= 2.0 && e < 30) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 1024.0);
        return {s, 5'(e), 10'(m)};
    endfunction

    // PE model: product registered after the operand cycle, sum one cycle later.
    real  prod_r = 0.0;
    real  acc_r  = 0.0;
    logic acc_flag_q = 1'b0;
    always @(posedge clk) begin
        prod_r     <= h2r(bus.pe_wgt) * h2r(bus.pe_ipt);
        acc_flag_q <= bus.pe_accum;
        acc_r      <= acc_flag_q ? (acc_r + prod_r) : prod_r;
    end
    always_comb bus.pe_result = h2h_from_real(acc_r);

    typedef struct {
        logic [15:0] data;
        int unsigned lat;
    } exp_t;
    exp_t        sb_q[$];
    int unsigned start_cyc = 0;
    int unsigned rise_cyc  = 0;

    initial begin : monitor
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.res_valid && !prev_valid) rise_cyc = cyc;
            if (!rst && bus.res_valid && bus.res_ready) begin
                check_eq("sb_pending", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("res_data", bus.res_data, e.data);
                    check_eq("latency", rise_cyc - start_cyc, e.lat);
                end
            end
            prev_valid = rst ? 1'b0 : bus.res_valid;
        end
    end

    logic [15:0] wv[4];
    logic [15:0] xv[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command from IDLE; stops driving before element stop_at if stop_at < n.
    task automatic send_cmd(input int n, input int bub_at, input int bub_n,
                            input logic [15:0] exp_res, input bit push, input int stop_at);
        exp_t e;
        int   guard;
        bus.start = 1'b1;
        bus.len   = 8'(n);
        start_cyc = cyc;
        if (push) begin
            e.data = exp_res;
            e.lat  = n + 4 + bub_n;
            sb_q.push_back(e);
        end
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) begin
                bus.in_valid = 1'b0;
                return;
            end
            if (i == bub_at) begin
                for (int b = 0; b < bub_n; b++) begin
                    bus.in_valid = 1'b0;
                    bus.in_wgt   = 16'hFFFF;
                    bus.in_ipt   = 16'hFFFF;
                    tick();
                    check_eq("bubble_wgt", bus.pe_wgt, 16'h0000);
                    check_eq("bubble_ipt", bus.pe_ipt, 16'h0000);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_wgt   = wv[i];
            bus.in_ipt   = xv[i];
            guard = 0;
            @(negedge clk);
            while (!bus.in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.in_ready) check_eq("in_ready_timeout", bus.in_ready, 1);
            tick();
            check_eq("pe_accum", bus.pe_accum, (i != 0));
            check_eq("pe_wgt", bus.pe_wgt, wv[i]);
            check_eq("pe_ipt", bus.pe_ipt, xv[i]);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((bus.busy || sb_q.size() != 0) && guard < 60) begin
            tick();
            guard++;
        end
        if (bus.busy || sb_q.size() != 0) check_eq("idle_timeout", bus.busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_in_ready"}, bus.in_ready, 0);
        check_eq({tag, "_res_valid"}, bus.res_valid, 0);
        check_eq({tag, "_res_data"}, bus.res_data, 0);
        check_eq({tag, "_pe_wgt"}, bus.pe_wgt, 0);
        check_eq({tag, "_pe_ipt"}, bus.pe_ipt, 0);
        check_eq({tag, "_pe_accum"}, bus.pe_accum, 0);
    endtask

    initial begin : global_timeout
        #200000;
        failures++;
        $display("FAIL global_timeout: got running, expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int guard;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_wgt    = '0;
        bus.in_ipt    = '0;
        bus.res_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic N=3: 1*2 + 2*2 + 3*2 = 12.
        wv = '{16'h3C00, 16'h4000, 16'h4200, 16'h0000};
        xv = '{16'h4000, 16'h4000, 16'h4000, 16'h0000};
        send_cmd(3, -1, 0, 16'h4A00, 1'b1, 99);
        wait_idle();

        // N=1 issued in the first IDLE cycle after the previous result.
        wv[0] = 16'h4400;
        xv[0] = 16'h3C00;
        send_cmd(1, -1, 0, 16'h4400, 1'b1, 99);
        wait_idle();

        // Two bubbles between the first and second elements.
        wv = '{16'h3C00, 16'h4000, 16'h4200, 16'h0000};
        xv = '{16'h4000, 16'h4000, 16'h4000, 16'h0000};
        send_cmd(3, 1, 2, 16'h4A00, 1'b1, 99);
        wait_idle();

        // Result back-pressure with a start pulse while holding the result.
        bus.res_ready = 1'b0;
        send_cmd(3, -1, 0, 16'h4A00, 1'b1, 99);
        guard = 0;
        while (!bus.res_valid && guard < 30) begin
            tick();
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            check_eq("hold_valid", bus.res_valid, 1);
            check_eq("hold_data", bus.res_data, 16'h4A00);
            bus.start = (k == 2);
            bus.len   = 8'd2;
            tick();
        end
        bus.start = 1'b0;
        check_eq("hold_busy", bus.busy, 1);
        bus.res_ready = 1'b1;
        wait_idle();
        tick();
        check_eq("stale_start", bus.busy, 0);

        // Back-to-back N=2 must not carry over the previous 12.0.
        wv = '{16'h3C00, 16'h3C00, 16'h0000, 16'h0000};
        xv = '{16'h3C00, 16'h3C00, 16'h0000, 16'h0000};
        send_cmd(2, -1, 0, 16'h4000, 1'b1, 99);
        wait_idle();

        // len=0 is ignored.
        bus.start = 1'b1;
        bus.len   = 8'd0;
        tick();
        bus.start = 1'b0;
        check_eq("len0_busy", bus.busy, 0);
        tick();
        check_eq("len0_busy2", bus.busy, 0);
        check_eq("len0_in_ready", bus.in_ready, 0);

        // Reset mid-FEED after 2 of 4 elements; nothing must come out.
        wv = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        xv = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        send_cmd(4, -1, 0, 16'h0000, 1'b0, 2);
        check_eq("midfeed_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        tick();
        check_eq("post_rst_busy", bus.busy, 0);

        wv[0] = 16'h4400;
        xv[0] = 16'h3C00;
        send_cmd(1, -1, 0, 16'h4400, 1'b1, 99);
        wait_idle();
        repeat (3) tick();
        check_eq("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
